// File: rtl/write_ram_mem_if.sv
// rtl/write_ram_mem_if.sv - job/RAM-port bundle for the 32-byte message RAM writer
//
// Purpose: groups the job handshake (start, msg_in, busy, done, valid,
// bad_index) and the single-port RAM write port (address, ram_data, wren).
//   master : key-search controller side (drives start/msg_in, observes the rest)
//   slave  : write_ram_mem side
interface write_ram_mem_if #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
);
  logic                    start;
  logic [DEPTH-1:0][7:0]   msg_in;
  logic [ADDR_W-1:0]       address;
  logic [7:0]              ram_data;
  logic                    wren;
  logic                    busy;
  logic                    done;
  logic                    valid;
  logic [ADDR_W-1:0]       bad_index;

  modport master (
    output start, msg_in,
    input  address, ram_data, wren, busy, done, valid, bad_index
  );

  modport slave (
    input  start, msg_in,
    output address, ram_data, wren, busy, done, valid, bad_index
  );
endinterface

// File: rtl/write_ram_mem.sv
// rtl/write_ram_mem.sv - writes a DEPTH-byte message into RAM while checking the plaintext alphabet
//
// Purpose: on a rising edge of start (from IDLE or DONE) snapshots msg_in and
// writes it byte-by-byte (one WRITE + one NEXT cycle per byte) into a
// single-port RAM, flagging the first byte outside {a-z, space}.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : write_ram_mem_if.slave
//            start in, msg_in in, address/ram_data/wren out (RAM port),
//            busy/done/valid/bad_index out (job status)
module write_ram_mem #(
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = 5,
  parameter bit CHECK_EN     = 1'b1,
  parameter bit ABORT_ON_BAD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  write_ram_mem_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    NEXT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t                state, state_n;
  logic                  start_q;
  logic [DEPTH-1:0][7:0] snap;
  logic [ADDR_W-1:0]     idx;
  logic [ADDR_W-1:0]     idx_inc;
  logic [ADDR_W-1:0]     addr_r;
  logic [7:0]            data_r;
  logic                  bad_r;
  logic [ADDR_W-1:0]     bad_idx_r;
  logic [7:0]            cur_byte;
  logic                  launch;
  logic                  byte_bad;
  logic                  first_bad;

  // Launch only on a start edge while parked; edges during a job are dropped.
  assign launch   = bus.start && !start_q && (state == IDLE || state == DONE);
  assign cur_byte = snap[idx];
  assign idx_inc  = idx + 1'b1;
  assign byte_bad = !(((cur_byte >= 8'h61) && (cur_byte <= 8'h7A)) || (cur_byte == 8'h20));
  // Only the first illegal byte of a job is recorded.
  assign first_bad = CHECK_EN && (state == WRITE) && byte_bad && !bad_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    bus.wren  = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.valid = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_n = WRITE;
      end
      WRITE: begin
        bus.wren = 1'b1;
        bus.busy = 1'b1;
        if (first_bad && ABORT_ON_BAD) state_n = DONE;
        else                           state_n = NEXT;
      end
      NEXT: begin
        bus.busy = 1'b1;
        if (idx == LAST) state_n = DONE;
        else             state_n = WRITE;
      end
      DONE: begin
        bus.done  = 1'b1;
        bus.valid = !bad_r;
        if (launch) state_n = WRITE;
      end
      default: state_n = IDLE;
    endcase
  end

  // address/ram_data are loaded on the way into WRITE so they are stable for
  // the whole WRITE cycle and simply hold afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= 1'b0;
      snap      <= '0;
      idx       <= '0;
      addr_r    <= '0;
      data_r    <= '0;
      bad_r     <= 1'b0;
      bad_idx_r <= '0;
    end else begin
      start_q <= bus.start;
      if (launch) begin
        snap      <= bus.msg_in;
        idx       <= '0;
        addr_r    <= '0;
        data_r    <= bus.msg_in[0];
        bad_r     <= 1'b0;
        bad_idx_r <= '0;
      end else begin
        if (first_bad) begin
          bad_r     <= 1'b1;
          bad_idx_r <= idx;
        end
        if (state == NEXT && idx != LAST) begin
          idx    <= idx_inc;
          addr_r <= idx_inc;
          data_r <= snap[idx_inc];
        end
      end
    end
  end

  assign bus.address   = addr_r;
  assign bus.ram_data  = data_r;
  assign bus.bad_index = bad_idx_r;

endmodule

// File: tb/tb_write_ram_mem.sv
// tb/tb_write_ram_mem.sv - scoreboard bench for write_ram_mem (three parameter variants)
module tb_write_ram_mem;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  typedef logic [DEPTH-1:0][7:0] msg_t;
  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int cyc; int valid; int bad; } dn_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  // index 0: CHECK_EN=1 ABORT_ON_BAD=1, 1: CHECK_EN=1 ABORT_ON_BAD=0, 2: CHECK_EN=0
  logic              start_v    [3];
  msg_t              msg_v      [3];
  logic [ADDR_W-1:0] address_v  [3];
  logic [7:0]        ram_data_v [3];
  logic              wren_v     [3];
  logic              busy_v     [3];
  logic              done_v     [3];
  logic              valid_v    [3];
  logic [ADDR_W-1:0] bad_v      [3];
  logic              done_p     [3];
  msg_t              ram        [3];

  wr_t wq [3][$];
  dn_t dq [3][$];

  write_ram_mem_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus_a ();
  write_ram_mem_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus_b ();
  write_ram_mem_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus_c ();

  write_ram_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CHECK_EN(1'b1), .ABORT_ON_BAD(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  write_ram_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CHECK_EN(1'b1), .ABORT_ON_BAD(1'b0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  write_ram_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CHECK_EN(1'b0), .ABORT_ON_BAD(1'b1))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  assign bus_a.start = start_v[0];  assign bus_a.msg_in = msg_v[0];
  assign bus_b.start = start_v[1];  assign bus_b.msg_in = msg_v[1];
  assign bus_c.start = start_v[2];  assign bus_c.msg_in = msg_v[2];

  assign address_v[0] = bus_a.address; assign ram_data_v[0] = bus_a.ram_data; assign wren_v[0] = bus_a.wren;
  assign busy_v[0] = bus_a.busy; assign done_v[0] = bus_a.done; assign valid_v[0] = bus_a.valid; assign bad_v[0] = bus_a.bad_index;
  assign address_v[1] = bus_b.address; assign ram_data_v[1] = bus_b.ram_data; assign wren_v[1] = bus_b.wren;
  assign busy_v[1] = bus_b.busy; assign done_v[1] = bus_b.done; assign valid_v[1] = bus_b.valid; assign bad_v[1] = bus_b.bad_index;
  assign address_v[2] = bus_c.address; assign ram_data_v[2] = bus_c.ram_data; assign wren_v[2] = bus_c.wren;
  assign busy_v[2] = bus_c.busy; assign done_v[2] = bus_c.done; assign valid_v[2] = bus_c.valid; assign bad_v[2] = bus_c.bad_index;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: written on the edge that ends a wren cycle.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++)
      if (wren_v[d] === 1'b1) ram[d][address_v[d]] <= ram_data_v[d];
  end

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_msg(string name, msg_t act, msg_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops an expectation whenever a DUT writes or raises done.
  wr_t w;
  dn_t dn;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (wren_v[d] === 1'b1) begin
        if (wq[d].size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write dut%0d: got addr %0d expected no write (cyc %0d)", d, address_v[d], cyc);
        end else begin
          w = wq[d].pop_front();
          chk($sformatf("wr_addr dut%0d", d), int'(address_v[d]), w.addr);
          chk($sformatf("wr_data dut%0d a%0d", d, w.addr), int'(ram_data_v[d]), w.data);
          chk($sformatf("wr_cycle dut%0d a%0d", d, w.addr), cyc, w.cyc);
        end
      end
      if (done_v[d] === 1'b1 && done_p[d] !== 1'b1) begin
        if (dq[d].size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done dut%0d: got done=1 expected no done (cyc %0d)", d, cyc);
        end else begin
          dn = dq[d].pop_front();
          chk($sformatf("done_cycle dut%0d", d), cyc, dn.cyc);
          chk($sformatf("valid dut%0d", d), int'(valid_v[d]), dn.valid);
          if (dn.valid == 0) chk($sformatf("bad_index dut%0d", d), int'(bad_v[d]), dn.bad);
          else if (d == 2)   chk("bad_index dut2", int'(bad_v[d]), dn.bad);
          chk($sformatf("busy_at_done dut%0d", d), int'(busy_v[d]), 0);
        end
      end
      done_p[d] = done_v[d];
    end
  end

  function automatic msg_t pad(string s);
    msg_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = (i < s.len()) ? s[i] : 8'h20;
    return m;
  endfunction

  // Drive a start edge and queue the expected writes/done. cycle E+n is seen
  // at the negedge where cyc == e+n.
  task automatic launch(input int d, input msg_t m, input int nwr, input int done_off,
                        input int v, input int b, input bit hold, output int e);
    @(negedge clk);
    msg_v[d]   = m;
    start_v[d] = 1'b1;
    e = cyc;
    for (int i = 0; i < nwr; i++) wq[d].push_back('{addr: i, data: int'(m[i]), cyc: e + 1 + 2*i});
    if (done_off >= 0) dq[d].push_back('{cyc: e + done_off, valid: v, bad: b});
    @(negedge clk);
    if (!hold) start_v[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((wq[d].size() != 0 || dq[d].size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (wq[d].size() != 0 || dq[d].size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout dut%0d: got %0d writes/%0d dones pending expected 0", d, wq[d].size(), dq[d].size());
      wq[d].delete();
      dq[d].delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_address"},   int'(address_v[0]),  0);
    chk({tag, "_ram_data"},  int'(ram_data_v[0]), 0);
    chk({tag, "_wren"},      int'(wren_v[0]),     0);
    chk({tag, "_busy"},      int'(busy_v[0]),     0);
    chk({tag, "_done"},      int'(done_v[0]),     0);
    chk({tag, "_valid"},     int'(valid_v[0]),    0);
    chk({tag, "_bad_index"}, int'(bad_v[0]),      0);
  endtask

  msg_t m1, m2, m3, m4, m5, mff, ma;
  int   e;

  initial begin
    cyc = 0; n_cmp = 0; n_bad = 0; reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0; msg_v[d] = '0; done_p[d] = 1'b0; ram[d] = '0;
    end
    m1 = pad("hello world");
    m2 = pad("abcde");            m2[5] = 8'h41;
    m3 = pad("the quick brown fox jumps over a");
    m3[3] = 8'h7B; m3[20] = 8'h60;
    m4 = pad("snapshot test");
    m5 = pad("reset midway job");
    for (int i = 0; i < DEPTH; i++) begin mff[i] = 8'hFF; ma[i] = 8'h41; end

    repeat (3) @(negedge clk);
    chk_reset_a("reset");
    reset = 1'b0;
    @(negedge clk);

    // full legal job: 32 writes, done at E+65, valid
    launch(0, m1, 32, 65, 1, 0, 1'b0, e);
    wait_idle(0);
    chk_msg("ram_hello", ram[0], m1);

    // illegal byte 5 with abort: writes 0..5, done at E+12
    launch(0, m2, 6, 12, 0, 5, 1'b0, e);
    wait_idle(0);
    chk("abort_done_held", int'(done_v[0]), 1);

    // two illegal bytes without abort: first one is reported
    launch(1, m3, 32, 65, 0, 3, 1'b0, e);
    wait_idle(1);
    chk_msg("ram_no_abort", ram[1], m3);

    // msg_in change and a second start edge mid-job are ignored
    launch(0, m4, 32, 65, 1, 0, 1'b0, e);
    wait_to(e + 3);
    msg_v[0] = ma;
    wait_to(e + 9);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0);
    chk_msg("ram_snapshot", ram[0], m4);

    // reset mid-job: bytes 0..9 only, then reset values, then a clean rerun
    launch(0, m5, 10, -1, 0, 0, 1'b0, e);
    wait_to(e + 20);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_a("midreset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("midreset_pending", wq[0].size(), 0);
    launch(0, m1, 32, 65, 1, 0, 1'b0, e);
    wait_idle(0);
    chk_msg("ram_after_reset", ram[0], m1);

    // alphabet check disabled: all 0xFF accepted; start held high does not relaunch
    launch(2, mff, 32, 65, 1, 0, 1'b1, e);
    wait_idle(2);
    repeat (10) @(negedge clk);
    chk("hold_done", int'(done_v[2]), 1);
    chk("hold_busy", int'(busy_v[2]), 0);
    chk_msg("ram_ff", ram[2], mff);
    start_v[2] = 1'b0;
    @(negedge clk);
    launch(2, m1, 32, 65, 1, 0, 1'b0, e);
    wait_idle(2);
    chk_msg("ram_relaunch", ram[2], m1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
